modn_scan_counter: RTL



---
 rtl/modn_scan_counter_pkg.sv | 11 +
 rtl/modn_scan_counter_tick.sv | 20 ++
 rtl/modn_scan_counter.sv | 37 +++
 3 files changed

// File: rtl/modn_scan_counter_pkg.sv
// modn_scan_counter_pkg: shared width helper and select polarity constants
package modn_scan_counter_pkg;
  localparam bit SEL_ACTIVE_LOW = 1'b1;
  localparam bit SEL_ACTIVE_HIGH = 1'b0;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/modn_scan_counter_tick.sv
// tick_gen: clock-enable prescaler emitting one tick every DIV enabled cycles
module tick_gen
  import modn_scan_counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  logic [PW-1:0] pre;
  always_ff @(posedge clk)
    if (rst || clr) pre <= '0;
    else if (en) pre <= (pre == LAST) ? '0 : pre + PW'(1);
  assign tick = en & (pre == LAST);
endmodule

// File: rtl/modn_scan_counter.sv
// modn_scan_counter: prescaled mod-N up/down counter with load, cascade tc and one-hot select
module modn_scan_counter
  import modn_scan_counter_pkg::*;
#(
  parameter int MOD = 4,
  parameter int DIV = 1,
  parameter bit SEL_ACT_LOW = SEL_ACTIVE_LOW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           up,
  input  logic           load,
  input  logic [clog2(MOD)-1:0] load_val,
  output logic [clog2(MOD)-1:0] out,
  output logic           tick,
  output logic           tc,
  output logic [MOD-1:0] sel
);
  localparam int W = clog2(MOD);
  localparam logic [W-1:0] MAX = W'(MOD - 1);
  localparam bit ON = (SEL_ACT_LOW == SEL_ACTIVE_HIGH);
  logic [W-1:0] nxt;
  tick_gen #(.DIV(DIV)) u_tick (.clk(clk), .rst(rst), .en(en), .clr(load), .tick(tick));
  assign tc = tick & ~load & (up ? (out == MAX) : (out == '0));
  always_comb begin
    nxt = out;
    if (load) nxt = (int'(load_val) > MOD - 1) ? MAX : load_val;
    else if (tick) nxt = up ? ((out == MAX) ? '0 : out + W'(1)) : ((out == '0) ? MAX : out - W'(1));
  end
  always_ff @(posedge clk)
    if (rst) out <= '0;
    else out <= nxt;
  for (genvar i = 0; i < MOD; i++) begin : g_sel
    assign sel[i] = (out == W'(i)) ? ON : ~ON;
  end
endmodule
